// File: rtl/psum_adder_tree_pipe.sv
// Pipelined partial-sum adder tree with cross-beat group accumulation.
// N_IN signed operands are reduced through ceil(log2(N_IN)) registered adder
// levels. The root sum is then folded into an accumulator across first/last
// delimited groups, and the group total is clamped or truncated to OW bits.
// A single advance signal freezes the whole pipe while a result waits downstream.

// One registered two-input adder node of the tree.
module psum_add_node #(
  parameter int AW = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic signed [AW-1:0] a,
  input  logic signed [AW-1:0] b,
  output logic signed [AW-1:0] s
);
  // register the pair sum whenever the pipe advances
  always_ff @(posedge clk) begin
    if (rst)     s <= '0;
    else if (en) s <= a + b;
  end
endmodule

module psum_adder_tree_pipe #(
  parameter int N_IN = 14,
  parameter int DW   = 16,
  parameter int AW   = 24,
  parameter int OW   = 16,
  parameter int SAT  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] in_data [0:N_IN-1],
  input  logic                 in_first,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [OW-1:0] out_sum,
  output logic                 out_sat
);
  localparam int L = $clog2(N_IN);

  // node count at tree level k (level 0 = the raw operands)
  function automatic int lvl_cnt(input int k);
    return (N_IN + (1 << k) - 1) >> k;
  endfunction

  // start index of level k inside the flattened node array
  function automatic int lvl_off(input int k);
    int o;
    o = 0;
    for (int i = 0; i < k; i++) o += lvl_cnt(i);
    return o;
  endfunction

  localparam int TOT = lvl_off(L + 1);

  // every node of every level, level 0 first; each entry has exactly one driver
  logic [AW-1:0] lvl [TOT];

  logic adv;
  logic [L:1] vld_pipe, fst_pipe, lst_pipe;

  // one global advance: everything moves unless a result is stuck at the output
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // level 0: sign-extend operands to accumulator width so the tree never truncates
  for (genvar j = 0; j < N_IN; j++) begin : g_in
    assign lvl[j] = {{(AW-DW){in_data[j][DW-1]}}, in_data[j]};
  end

  // levels 1..L: pair up the previous level; an odd leftover pairs with zero
  for (genvar k = 1; k <= L; k++) begin : g_lvl
    localparam int CNT  = lvl_cnt(k);
    localparam int PCNT = lvl_cnt(k-1);
    localparam int OFF  = lvl_off(k);
    localparam int POFF = lvl_off(k-1);
    for (genvar j = 0; j < CNT; j++) begin : g_node
      if (2*j+1 < PCNT) begin : g_pair
        psum_add_node #(.AW(AW)) u_node (
          .clk(clk), .rst(rst), .en(adv),
          .a(lvl[POFF+2*j]), .b(lvl[POFF+2*j+1]), .s(lvl[OFF+j])
        );
      end else begin : g_pad
        psum_add_node #(.AW(AW)) u_node (
          .clk(clk), .rst(rst), .en(adv),
          .a(lvl[POFF+2*j]), .b({AW{1'b0}}), .s(lvl[OFF+j])
        );
      end
    end
  end

  // valid/first/last tags travel alongside the tree data, one stage per level
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      fst_pipe <= '0;
      lst_pipe <= '0;
    end else if (adv) begin
      vld_pipe[1] <= in_valid;
      fst_pipe[1] <= in_first;
      lst_pipe[1] <= in_last;
      for (int i = 2; i <= L; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        fst_pipe[i] <= fst_pipe[i-1];
        lst_pipe[i] <= lst_pipe[i-1];
      end
    end
  end

  logic signed [AW-1:0] tree, acc, acc_nxt;
  logic signed [OW-1:0] res;
  logic                 res_sat, ovf;

  assign tree = lvl[TOT-1];
  // a first beat restarts the group; acc is already zero after a last
  assign acc_nxt = fst_pipe[L] ? tree : acc + tree;
  // value fits in OW bits iff all bits from OW-1 upward agree with the sign
  assign ovf = !((&acc_nxt[AW-1:OW-1]) || !(|acc_nxt[AW-1:OW-1]));

  // clamp to the OW range or keep the low bits
  always_comb begin
    res     = acc_nxt[OW-1:0];
    res_sat = 1'b0;
    if (SAT != 0 && ovf) begin
      res_sat = 1'b1;
      res     = acc_nxt[AW-1] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
    end
  end

  // accumulate stage and output register; a last beat publishes and clears acc
  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_sat   <= 1'b0;
    end else if (adv) begin
      if (vld_pipe[L] && lst_pipe[L]) begin
        acc       <= '0;
        out_sum   <= res;
        out_sat   <= res_sat;
        out_valid <= 1'b1;
      end else begin
        if (vld_pipe[L]) acc <= acc_nxt;
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: doc/psum_adder_tree_pipe.md
Name: psum_adder_tree_pipe

Overview:
- Parametrised, pipelined successor to the 14-input combinational partial-sum adder tree.
- Reduces N_IN signed operands per beat through a registered binary tree, one register stage per level.
- An accumulate stage then sums tree results across multi-beat groups delimited by first/last tags.
- Sits between a PE-array column and the psum buffer.
- Uses valid/ready handshakes on both sides, a global stall, and optional output saturation.

Parameters:
- N_IN, 14: operands per beat (>=2). Odd operand counts are zero-padded at each level.
- DW, 16: signed operand width.
- AW, 24: signed accumulator width. Must be >= DW+clog2(N_IN).
- OW, 16: signed output width (<= AW).
- SAT, 1: 1 = clamp the AW result to the OW range; 0 = truncate to the low OW bits.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid && in_ready
- in_data  in  N_IN x DW (unpacked array [0:N_IN-1])  signed operands
- in_first  in  1  beat starts an accumulation group
- in_last  in  1  beat ends an accumulation group
- out_valid  out  1  group result valid
- out_ready  in  1  downstream accepts the result
- out_sum  out  OW  signed group result
- out_sat  out  1  clamp occurred on this result (always 0 when SAT=0)

Behaviour:
- L = ceil(log2(N_IN)) tree levels, each registered. Level k holds ceil(prev/2) sums. Odd leftovers pair with 0.
- Tree arithmetic is full-precision and sign-extended to AW. There is no intermediate truncation.
- Global advance: adv = !out_valid || out_ready; in_ready = adv.
  - All tree registers, valid/first/last tag shift registers, the accumulator and the output register update only when adv=1.
  - When adv=0, everything holds, including bubbles.
- When adv=1 and in_valid=0, a bubble (valid=0) enters stage 1.
- Accumulate stage, acting on a valid beat t leaving level L when adv=1:
  - If first_t, or the previous group has just ended: acc <= tree_t.
  - Otherwise: acc <= acc + tree_t, with AW two's-complement wrap.
  - If last_t: out_sum <= clamp/truncate(acc_next), out_sat updated, out_valid <= 1, acc <= 0.
  - If !last_t: out_valid <= 0 when the current output is consumed (adv=1).
- Bubble at the accumulate stage with adv=1: acc holds, and out_valid <= 0.
- A beat with both first and last set is a single-beat group. Latency from accept to out_valid is exactly L+1 cycles with no stalls.
- A first beat arriving mid-group restarts the group. The partial sum is silently discarded.
- A beat with neither flag set, arriving after a last, accumulates onto 0 (acc was cleared), so it behaves as an implicit first.
- SAT=1 clamp bounds: [-2^(OW-1), 2^(OW-1)-1]. out_sat=1 iff the clamp changed the value.
- out_valid, out_sum and out_sat stay stable while out_valid && !out_ready.
- Throughput is 1 beat per cycle when out_ready=1. Results emerge in input order.
- Reset:
  - out_valid=0, out_sum=0, out_sat=0, acc=0, all stage valids=0.
  - in_ready=1 during and after reset, since out_valid=0.
  - Reset mid-operation discards all in-flight beats and partial sums. No stale result appears after reset.

Test Plan (N_IN=14, DW=16, AW=24, OW=16, so L=4 and latency 5):
- Single beat, all operands 1, first=last=1, out_ready=1 -> out_sum=14, out_sat=0, out_valid exactly 5 cycles after accept for 1 cycle.
- Signed mix: in[k]=-1 for all k -> out_sum=0xFFF2 (-14). in[k]=k-7 -> out_sum=-7 (0xFFF9).
- Saturation: all 0x7FFF:
  - SAT=1 -> out_sum=0x7FFF, out_sat=1.
  - SAT=0 -> out_sum=0xFFF2 (low 16 bits of 458738), out_sat=0.
  - All 0x8000 with SAT=1 -> 0x8000, out_sat=1.
- Accumulation: three beats of all 1s tagged first / none / last, back-to-back -> exactly one out_valid with out_sum=42. A restart using first on beat 2 -> out_sum=28.
- Backpressure: 6 single-beat groups back-to-back with operands=i (i=1..6), out_ready=0 for 3 cycles once the first result appears -> in_ready=0 during the stall, results 14, 28, 42, 56, 70, 84 in order, none lost or duplicated, outputs stable while stalled.
- Reset: assert rst for 1 cycle with 3 beats in flight and out_valid=1 -> out_valid=0, out_sum=0 next cycle, no result for those beats. A fresh single beat then yields its correct sum after 5 cycles.
